// File: rtl/riscv_ctrl_para.sv
// Shared control constants for the RV32IM execute stage: operand width,
// base ALU command encodings and M-extension funct3 codes.
package riscv_ctrl_para;

  localparam int datawidth = 32;

  // Base group, selected when IsMul = 0
  localparam logic [3:0] ALU_OPERATION_ADD  = 4'd0;
  localparam logic [3:0] ALU_OPERATION_SUB  = 4'd1;
  localparam logic [3:0] ALU_OPERATION_SLL  = 4'd2;
  localparam logic [3:0] ALU_OPERATION_SLT  = 4'd3;
  localparam logic [3:0] ALU_OPERATION_SLTU = 4'd4;
  localparam logic [3:0] ALU_OPERATION_XOR  = 4'd5;
  localparam logic [3:0] ALU_OPERATION_SRL  = 4'd6;
  localparam logic [3:0] ALU_OPERATION_SRA  = 4'd7;
  localparam logic [3:0] ALU_OPERATION_OR   = 4'd8;
  localparam logic [3:0] ALU_OPERATION_AND  = 4'd9;
  localparam logic [3:0] ALU_OPERATION_BEQ  = 4'd10;
  localparam logic [3:0] ALU_OPERATION_BNE  = 4'd11;
  localparam logic [3:0] ALU_OPERATION_BLT  = 4'd12;
  localparam logic [3:0] ALU_OPERATION_BGE  = 4'd13;
  localparam logic [3:0] ALU_OPERATION_BLTU = 4'd14;
  localparam logic [3:0] ALU_OPERATION_BGEU = 4'd15;

  // M group, funct3 taken from ALU_cmd[2:0]
  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  function automatic logic is_branch_cmd(input logic [3:0] cmd);
    return cmd >= ALU_OPERATION_BEQ;
  endfunction

endpackage

// File: rtl/riscv_alu_if.sv
// Operand/command bundle between the ID/EX latches and the execute ALU,
// plus the registered result and branch flag returned to the pipeline.
interface riscv_alu_if #(
  parameter int datawidth = riscv_ctrl_para::datawidth
);
  logic [datawidth-1:0] a;
  logic [datawidth-1:0] b;
  logic [3:0]           ALU_cmd;
  logic                 IsMul;
  logic [datawidth-1:0] ALU_result;
  logic                 PC_branch;

  modport master (
    output a, b, ALU_cmd, IsMul,
    input  ALU_result, PC_branch
  );

  modport slave (
    input  a, b, ALU_cmd, IsMul,
    output ALU_result, PC_branch
  );
endinterface

// File: rtl/alu_muldiv.sv
// Combinational RV32M unit: signed/unsigned multiply (high and low halves)
// and divide/remainder with the architectural divide-by-zero and overflow results.
module alu_muldiv
  import riscv_ctrl_para::*;
#(
  parameter int datawidth = riscv_ctrl_para::datawidth
) (
  input  logic [datawidth-1:0] a,
  input  logic [datawidth-1:0] b,
  input  logic [2:0]           funct3,
  output logic [datawidth-1:0] result
);

  localparam logic [datawidth-1:0] MIN_NEG  = {1'b1, {(datawidth-1){1'b0}}};
  localparam logic [datawidth-1:0] ALL_ONES = {datawidth{1'b1}};
  localparam logic [datawidth-1:0] ONE      = {{(datawidth-1){1'b0}}, 1'b1};

  logic                   a_signed;
  logic                   b_signed;
  logic [2*datawidth-1:0] a_ext;
  logic [2*datawidth-1:0] b_ext;
  logic [2*datawidth-1:0] prod;

  // Extending each operand by its own sign (or zero) to double width makes the
  // truncated unsigned product equal to the exact 33x33 signed product.
  assign a_signed = (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU);
  assign b_signed = (funct3 == FUNCT3_MULH);
  assign a_ext    = {{datawidth{a_signed & a[datawidth-1]}}, a};
  assign b_ext    = {{datawidth{b_signed & b[datawidth-1]}}, b};
  assign prod     = a_ext * b_ext;

  logic                        b_zero;
  logic                        div_ovf;
  logic [datawidth-1:0]        b_safe_s;
  logic [datawidth-1:0]        b_safe_u;
  logic signed [datawidth-1:0] quot_s;
  logic signed [datawidth-1:0] rem_s;
  logic [datawidth-1:0]        quot_u;
  logic [datawidth-1:0]        rem_u;

  assign b_zero  = (b == '0);
  assign div_ovf = (a == MIN_NEG) && (b == ALL_ONES);

  // Substitute a divisor of 1 on the special cases so the raw divider never
  // sees an undefined operation; those results are overridden below anyway.
  assign b_safe_s = (b_zero || div_ovf) ? ONE : b;
  assign b_safe_u = b_zero ? ONE : b;

  assign quot_s = $signed(a) / $signed(b_safe_s);
  assign rem_s  = $signed(a) % $signed(b_safe_s);
  assign quot_u = a / b_safe_u;
  assign rem_u  = a % b_safe_u;

  always_comb begin
    result = '0;
    case (funct3)
      FUNCT3_MUL:    result = prod[datawidth-1:0];
      FUNCT3_MULH,
      FUNCT3_MULHSU,
      FUNCT3_MULHU:  result = prod[2*datawidth-1:datawidth];
      FUNCT3_DIV: begin
        if (b_zero)       result = ALL_ONES;
        else if (div_ovf) result = MIN_NEG;
        else              result = quot_s;
      end
      FUNCT3_DIVU:   result = b_zero ? ALL_ONES : quot_u;
      FUNCT3_REM: begin
        if (b_zero)       result = a;
        else if (div_ovf) result = '0;
        else              result = rem_s;
      end
      FUNCT3_REMU:   result = b_zero ? a : rem_u;
      default:       result = '0;
    endcase
  end

endmodule

// File: rtl/riscv_alu.sv
// RV32IM execute-stage ALU: base ops, branch compare and M-extension results,
// muxed and registered once so every command has exactly one cycle of latency.
module riscv_alu
  import riscv_ctrl_para::*;
#(
  parameter int datawidth = riscv_ctrl_para::datawidth
) (
  input  logic        clk,
  input  logic        rst,
  riscv_alu_if.slave  alu_bus
);

  logic [datawidth-1:0] a;
  logic [datawidth-1:0] b;
  logic [3:0]           cmd;
  logic [4:0]           shamt;

  assign a     = alu_bus.a;
  assign b     = alu_bus.b;
  assign cmd   = alu_bus.ALU_cmd;
  assign shamt = b[4:0];

  logic [datawidth-1:0] md_result;

  alu_muldiv #(
    .datawidth (datawidth)
  ) u_muldiv (
    .a      (a),
    .b      (b),
    .funct3 (cmd[2:0]),
    .result (md_result)
  );

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  logic [datawidth-1:0] base_result;
  logic                 branch_taken;

  always_comb begin
    base_result  = '0;
    branch_taken = 1'b0;
    case (cmd)
      ALU_OPERATION_ADD:  base_result = a + b;
      ALU_OPERATION_SUB:  base_result = a - b;
      ALU_OPERATION_SLL:  base_result = a << shamt;
      ALU_OPERATION_SLT:  base_result = {{(datawidth-1){1'b0}}, lt_s};
      ALU_OPERATION_SLTU: base_result = {{(datawidth-1){1'b0}}, lt_u};
      ALU_OPERATION_XOR:  base_result = a ^ b;
      ALU_OPERATION_SRL:  base_result = a >> shamt;
      ALU_OPERATION_SRA:  base_result = $signed(a) >>> shamt;
      ALU_OPERATION_OR:   base_result = a | b;
      ALU_OPERATION_AND:  base_result = a & b;
      // Branch commands only produce the taken flag; the result stays zero.
      ALU_OPERATION_BEQ:  branch_taken = eq;
      ALU_OPERATION_BNE:  branch_taken = !eq;
      ALU_OPERATION_BLT:  branch_taken = lt_s;
      ALU_OPERATION_BGE:  branch_taken = !lt_s;
      ALU_OPERATION_BLTU: branch_taken = lt_u;
      ALU_OPERATION_BGEU: branch_taken = !lt_u;
      default: begin
        base_result  = '0;
        branch_taken = 1'b0;
      end
    endcase
  end

  logic [datawidth-1:0] result_d;
  logic [datawidth-1:0] result_q;
  logic                 branch_d;
  logic                 branch_q;

  always_comb begin
    result_d = base_result;
    branch_d = branch_taken & is_branch_cmd(cmd);
    if (alu_bus.IsMul) begin
      result_d = md_result;
      branch_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      branch_q <= 1'b0;
    end else begin
      result_q <= result_d;
      branch_q <= branch_d;
    end
  end

  assign alu_bus.ALU_result = result_q;
  assign alu_bus.PC_branch  = branch_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Directed-vector bench for riscv_alu: each operation is checked one cycle
// after it is applied, plus asynchronous reset behaviour around an edge.
module tb_riscv_alu;
  import riscv_ctrl_para::*;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  riscv_alu_if #(.datawidth(32)) alu_bus ();

  riscv_alu #(
    .datawidth (32)
  ) dut (
    .clk     (clk),
    .rst     (rst_n),
    .alu_bus (alu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Apply one operation after an edge, then sample 1 time unit after the next edge.
  task automatic run_op(input string tag, input logic mul, input logic [3:0] cmd,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_r, input logic exp_br);
    alu_bus.IsMul   = mul;
    alu_bus.ALU_cmd = cmd;
    alu_bus.a       = av;
    alu_bus.b       = bv;
    @(posedge clk);
    #1;
    $display("op %-8s a=%08h b=%08h -> result=%08h branch=%0b", tag, av, bv,
             alu_bus.ALU_result, alu_bus.PC_branch);
    check_val({tag, ".result"}, alu_bus.ALU_result, exp_r);
    check_val({tag, ".branch"}, {31'd0, alu_bus.PC_branch}, {31'd0, exp_br});
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    alu_bus.IsMul   = 1'b0;
    alu_bus.ALU_cmd = ALU_OPERATION_ADD;
    alu_bus.a       = 32'h1234_5678;
    alu_bus.b       = 32'h1111_1111;

    #2;
    check_val("reset.result", alu_bus.ALU_result, 32'h0);
    check_val("reset.branch", {31'd0, alu_bus.PC_branch}, 32'h0);
    @(posedge clk);
    #1;
    check_val("reset_hold.result", alu_bus.ALU_result, 32'h0);
    rst_n = 1'b1;

    // Base group
    run_op("ADD",  1'b0, 4'd0, 32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 1'b0);
    run_op("SUB",  1'b0, 4'd1, 32'h0000_000a, 32'h0000_0004, 32'h0000_0006, 1'b0);
    run_op("ADDW", 1'b0, 4'd0, 32'hffff_ffff, 32'h0000_0003, 32'h0000_0002, 1'b0);
    run_op("SLL",  1'b0, 4'd2, 32'hffff_f000, 32'hffff_fa5d, 32'h0000_0000, 1'b0);
    run_op("SLL1", 1'b0, 4'd2, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0);
    run_op("SLT",  1'b0, 4'd3, 32'hffff_f000, 32'h0000_0fff, 32'h0000_0001, 1'b0);
    run_op("SLTU", 1'b0, 4'd4, 32'hffff_fd21, 32'hffff_f0ac, 32'h0000_0000, 1'b0);
    run_op("SLTU1",1'b0, 4'd4, 32'h0000_0001, 32'hffff_ffff, 32'h0000_0001, 1'b0);
    run_op("XOR",  1'b0, 4'd5, 32'h000f_f000, 32'h0000_0004, 32'h000f_f004, 1'b0);
    run_op("SRL",  1'b0, 4'd6, 32'h000f_f000, 32'h0000_0004, 32'h0000_ff00, 1'b0);
    run_op("SRLN", 1'b0, 4'd6, 32'hf00f_f000, 32'h0000_0004, 32'h0f00_ff00, 1'b0);
    run_op("SRA",  1'b0, 4'd7, 32'hf00f_f000, 32'h0000_0004, 32'hff00_ff00, 1'b0);
    run_op("OR",   1'b0, 4'd8, 32'hf00f_0000, 32'hf00f_f000, 32'hf00f_f000, 1'b0);
    run_op("AND",  1'b0, 4'd9, 32'hf00f_f000, 32'hf00f_0000, 32'hf00f_0000, 1'b0);

    // Branches
    run_op("BEQ",   1'b0, 4'd10, 32'habcd_ef12, 32'habcd_ef12, 32'h0, 1'b1);
    run_op("BEQne", 1'b0, 4'd10, 32'hffff_ffff, 32'h0000_0001, 32'h0, 1'b0);
    run_op("BNE",   1'b0, 4'd11, 32'habcd_ef12, 32'habcd_ef12, 32'h0, 1'b0);
    run_op("BNEne", 1'b0, 4'd11, 32'hffff_ffff, 32'h0000_0001, 32'h0, 1'b1);
    run_op("BLT",   1'b0, 4'd12, 32'hffff_ffff, 32'h0000_0001, 32'h0, 1'b1);
    run_op("BGE",   1'b0, 4'd13, 32'hffff_ffff, 32'h0000_0001, 32'h0, 1'b0);
    run_op("BLTU",  1'b0, 4'd14, 32'hffff_ffff, 32'h0000_0001, 32'h0, 1'b0);
    run_op("BGEU",  1'b0, 4'd15, 32'hffff_ffff, 32'h0000_0001, 32'h0, 1'b1);

    // Multiply
    run_op("MUL",    1'b1, 4'd0, 32'hffff_ffff, 32'h0000_0002, 32'hffff_fffe, 1'b0);
    run_op("MULH",   1'b1, 4'd1, 32'hffff_ffff, 32'h0000_0002, 32'hffff_ffff, 1'b0);
    run_op("MULHSU", 1'b1, 4'd2, 32'hffff_ffff, 32'h0000_0002, 32'hffff_ffff, 1'b0);
    run_op("MULHU",  1'b1, 4'd3, 32'hffff_ffff, 32'h0000_0002, 32'h0000_0001, 1'b0);
    run_op("MULHmn", 1'b1, 4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("MULHSUm",1'b1, 4'd2, 32'h8000_0000, 32'h8000_0000, 32'hc000_0000, 1'b0);
    run_op("MULc8",  1'b1, 4'd8, 32'hffff_ffff, 32'h0000_0002, 32'hffff_fffe, 1'b0);

    // Divide / remainder
    run_op("DIV",    1'b1, 4'd4, 32'hffff_fff9, 32'h0000_0002, 32'hffff_fffd, 1'b0);
    run_op("REM",    1'b1, 4'd6, 32'hffff_fff9, 32'h0000_0002, 32'hffff_ffff, 1'b0);
    run_op("DIVn",   1'b1, 4'd4, 32'h0000_0007, 32'hffff_fffe, 32'hffff_fffd, 1'b0);
    run_op("REMn",   1'b1, 4'd6, 32'h0000_0007, 32'hffff_fffe, 32'h0000_0001, 1'b0);
    run_op("DIVU",   1'b1, 4'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000e, 1'b0);
    run_op("REMU",   1'b1, 4'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0);
    run_op("DIVUbig",1'b1, 4'd5, 32'h8000_0000, 32'hffff_ffff, 32'h0000_0000, 1'b0);
    run_op("DIVU0",  1'b1, 4'd5, 32'h0000_0007, 32'h0000_0000, 32'hffff_ffff, 1'b0);
    run_op("REMU0",  1'b1, 4'd7, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0);
    run_op("DIV0",   1'b1, 4'd4, 32'hffff_fff9, 32'h0000_0000, 32'hffff_ffff, 1'b0);
    run_op("REM0",   1'b1, 4'd6, 32'hffff_fff9, 32'h0000_0000, 32'hffff_fff9, 1'b0);
    run_op("DIVovf", 1'b1, 4'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1'b0);
    run_op("REMovf", 1'b1, 4'd6, 32'h8000_0000, 32'hffff_ffff, 32'h0000_0000, 1'b0);

    // Reset mid-stream: capture ADD 5,5, then drop rst between edges
    run_op("ADDrst", 1'b0, 4'd0, 32'h0000_0005, 32'h0000_0005, 32'h0000_000a, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    $display("rst low mid-cycle -> result=%08h branch=%0b", alu_bus.ALU_result, alu_bus.PC_branch);
    check_val("rst_async.result", alu_bus.ALU_result, 32'h0);
    check_val("rst_async.branch", {31'd0, alu_bus.PC_branch}, 32'h0);
    @(posedge clk);
    #1;
    check_val("rst_held.result", alu_bus.ALU_result, 32'h0);
    alu_bus.ALU_cmd = 4'd1;
    alu_bus.a       = 32'h0000_000a;
    alu_bus.b       = 32'h0000_0004;
    #2;
    rst_n = 1'b1;
    #1;
    check_val("rst_release.result", alu_bus.ALU_result, 32'h0);
    @(posedge clk);
    #1;
    $display("first edge after release -> result=%08h", alu_bus.ALU_result);
    check_val("post_rst.result", alu_bus.ALU_result, 32'h0000_0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
